rom_stream_reader: RTL



---
 rtl/rom_reader_pkg.sv | 7 +
 rtl/rom_stream_reader.sv | 93 +++++++++
 2 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and default widths for the ROM stream reader.
package rom_reader_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/rom_stream_reader.sv
// Walks an external combinational ROM from a base address for a word count and
// streams the words through a one-entry valid/ready output register.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  done_q, done_d;
  logic                  load;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rem_d      = rem_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            rom_addr_d = base_addr;
            rem_d      = (length > DEPTH) ? DEPTH : length;
            state_d    = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        // Refill whenever the output slot is empty or drains this cycle.
        load = (rem_q != '0) && (!m_valid_q || m_ready);
        if (load) begin
          m_data_d   = rom_data;
          m_valid_d  = 1'b1;
          rom_addr_d = rom_addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      rem_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rem_q      <= rem_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == STREAM);
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
endmodule
